// File: rtl/ads1672_pkg.sv
// Shared types and constants for the ADS1672 serial-output-port emulator.
package ads1672_pkg;

   localparam int ADS1672_DATA_WIDTH = 24;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CONV,
      READY,
      SHIFT
   } emu_state_t;

endpackage

// File: rtl/ads1672_pin_sync.sv
// Multi-flop synchronizer for an asynchronous processor pin, with single-clock
// rise/fall pulses derived from the synchronized level.
module ads1672_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Shift the pin through the sync chain; keep last level for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {SYNC_STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain[0] <= pin;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
         prev <= level;
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/ads1672_adc_emu.sv
// ADS1672 serial output port emulator: periodic conversions announced on
// drdy_n, word shifted MSB-first on dout by the processor's sclk falls.
// Optional build macro ADS1672_EMU_RAMP_EN: words come from an internal ramp
// (0,1,2,...) instead of the sample_data/sample_valid source.
//
// state  | meaning
// IDLE   | start low, outputs quiet, counters cleared
// SETTLE | start seen, waiting SETTLE_CYCLES before first conversion
// CONV   | word just loaded; drdy_n driven low (after a 1-clk gap on overrun)
// READY  | drdy_n low, waiting for first sclk fall with cs_n low
// SHIFT  | frame being read; after DATA_WIDTH falls dout=0 until next conversion
module ads1672_adc_emu
   import ads1672_pkg::*;
#(
   parameter int DATA_WIDTH    = ADS1672_DATA_WIDTH,
   parameter int CONV_PERIOD   = 64,
   parameter int SETTLE_CYCLES = 8,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic [DATA_WIDTH-1:0] sample_data,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  drdy_n,
   output logic                  dout,
   output logic                  overrun
);

   localparam int TW = $clog2(CONV_PERIOD);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(CONV_PERIOD - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [BW-1:0] BITS_FULL   = BW'(DATA_WIDTH);

   emu_state_t            state, state_nxt;
   logic [TW-1:0]         per_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] word;
   logic [DATA_WIDTH-1:0] load_word;
   logic [DATA_WIDTH-1:0] word_next;

   logic start_s, start_rise, start_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_n_s, cs_n_rise, cs_n_fall;

   logic conv_event, overrun_evt, shift_en, drdy_n_nxt;
   logic fall_ok, frame_open, busy;

   ads1672_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_start (
      .clk(clk), .rst(rst), .pin(start),
      .level(start_s), .rise(start_rise), .fall(start_fall)
   );

   ads1672_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .pin(sclk),
      .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   ads1672_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
      .clk(clk), .rst(rst), .pin(cs_n),
      .level(cs_n_s), .rise(cs_n_rise), .fall(cs_n_fall)
   );

   // Only the level of start and cs_n and the falling edge of sclk matter here.
   logic unused_edges;
   assign unused_edges = ^{start_rise, start_fall, sclk_s, sclk_rise, cs_n_rise, cs_n_fall};

`ifdef ADS1672_EMU_RAMP_EN
   assign load_word    = word;
   assign word_next    = word + DATA_WIDTH'(1);
   assign sample_ready = 1'b0;
   logic unused_sample;
   assign unused_sample = ^{sample_data, sample_valid};
`else
   assign load_word    = sample_valid ? sample_data : word;
   assign word_next    = load_word;
   assign sample_ready = conv_event & sample_valid;
`endif

   assign busy       = (state == CONV) || (state == READY) || (state == SHIFT);
   assign fall_ok    = sclk_fall & ~cs_n_s;
   assign frame_open = (state == CONV) || (state == READY) ||
                       ((state == SHIFT) && (bit_cnt < BITS_FULL));
   assign dout       = busy && !cs_n_s && (bit_cnt < BITS_FULL) && shift_reg[DATA_WIDTH-1];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, conversion/overrun events and drdy_n; a conversion beats a
   // coincident sclk fall, and a start drop beats everything.
   always_comb begin
      state_nxt   = state;
      drdy_n_nxt  = 1'b1;
      conv_event  = 1'b0;
      overrun_evt = 1'b0;
      shift_en    = 1'b0;
      if (!start_s) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nxt  = SETTLE;
            SETTLE:  conv_event = (per_cnt == SETTLE_LAST);
            default: conv_event = (per_cnt == PERIOD_LAST);
         endcase
         if (conv_event) begin
            // On overrun drdy_n stays high one clk so the processor sees a new fall.
            overrun_evt = frame_open;
            drdy_n_nxt  = frame_open;
            state_nxt   = CONV;
         end else begin
            unique case (state)
               CONV: begin
                  state_nxt  = READY;
                  drdy_n_nxt = 1'b0;
               end
               READY: begin
                  if (fall_ok) begin
                     state_nxt = SHIFT;
                     shift_en  = 1'b1;
                  end else begin
                     drdy_n_nxt = 1'b0;
                  end
               end
               SHIFT:   shift_en = fall_ok && (bit_cnt < BITS_FULL);
               default: ;
            endcase
         end
      end
   end

   // Period timer, shift register, bit count, word source and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         word      <= '0;
         drdy_n    <= 1'b1;
         overrun   <= 1'b0;
      end else begin
         drdy_n  <= drdy_n_nxt;
         overrun <= overrun_evt;
         if (!start_s || (state == IDLE)) begin
            per_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef ADS1672_EMU_RAMP_EN
            word      <= '0;
`endif
         end else if (conv_event) begin
            per_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= load_word;
            word      <= word_next;
         end else begin
            per_cnt <= per_cnt + TW'(1);
            if (shift_en) begin
               shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
               bit_cnt   <= bit_cnt + BW'(1);
            end
         end
      end
   end

endmodule
